// File: rtl/safe_judge_if.sv
// Bundle of the submit/score signals between the game controller and safe_judge.
// The bench drives the master side and safe_judge takes the slave side.
interface safe_judge_if;
    // Handshake: submit is a one-cycle valid pulse. The judge is ready only while
    // idle; a submit presented while busy, finished, or during reset is dropped.
    logic            submit;
    logic [3:0][3:0] guess;
    logic [3:0][3:0] secret;
    logic [3:0]      nCorrect;
    logic [3:0]      nMisplaced;
    logic [1:0][3:0] tries;
    logic            win;
    logic            lose;
    logic            busy;
    logic            reject;

    modport master (
        output submit, guess, secret,
        input  nCorrect, nMisplaced, tries, win, lose, busy, reject
    );

    modport slave (
        input  submit, guess, secret,
        output nCorrect, nMisplaced, tries, win, lose, busy, reject
    );
endinterface

// File: rtl/safe_judge.sv
// Serial Mastermind-style scorer: exact hits, then misplaced hits, then a BCD try count.
// Optional macro SAFE_JUDGE_VALIDATE_EN refuses guesses containing digits above 9.
module safe_judge #(
    parameter int MAX_TRIES = 10
) (
    input  logic       clk,
    input  logic       reset,
    safe_judge_if.slave sj,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {IDLE, EXACT, MISP, UPDATE, DONE} state_t;

    localparam logic [3:0] MAX_TENS  = 4'(MAX_TRIES / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_TRIES % 10);

    state_t          state, state_nxt;
    logic [3:0][3:0] g_q, s_q;
    logic [3:0]      g_used, s_used;
    logic [2:0]      cor, mis;
    logic [3:0]      idx;
    logic [1:0]      gi, si;
    logic            exact_hit, mis_hit;
    logic            guess_ok, accept;
    logic [3:0]      units_nxt, tens_nxt;
    logic            is_max;

    assign state_dbg = state;
    assign sj.busy   = (state == EXACT) || (state == MISP) || (state == UPDATE);

`ifdef SAFE_JUDGE_VALIDATE_EN
    always_comb begin
        guess_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (sj.guess[i] > 4'd9) guess_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sj.reject <= 1'b0;
        else       sj.reject <= (state == IDLE) && sj.submit && !guess_ok;
    end
`else
    assign guess_ok  = 1'b1;
    assign sj.reject = 1'b0;
`endif

    assign accept = (state == IDLE) && sj.submit && guess_ok;

    // EXACT walks position idx[1:0]; MISP walks guess idx[3:2] against secret idx[1:0].
    always_comb begin
        gi        = (state == EXACT) ? idx[1:0] : idx[3:2];
        si        = idx[1:0];
        exact_hit = (g_q[si] == s_q[si]);
        mis_hit   = !g_used[gi] && !s_used[si] && (g_q[gi] == s_q[si]);
    end

    always_comb begin
        if (sj.tries[0] == 4'd9) begin
            units_nxt = 4'd0;
            tens_nxt  = sj.tries[1] + 4'd1;
        end else begin
            units_nxt = sj.tries[0] + 4'd1;
            tens_nxt  = sj.tries[1];
        end
        is_max = (tens_nxt == MAX_TENS) && (units_nxt == MAX_UNITS);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXACT;
            EXACT:   if (idx == 4'd3) state_nxt = MISP;
            MISP:    if (idx == 4'd15) state_nxt = UPDATE;
            UPDATE:  state_nxt = ((cor == 3'd4) || is_max) ? DONE : IDLE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            g_q           <= '0;
            s_q           <= '0;
            g_used        <= '0;
            s_used        <= '0;
            cor           <= '0;
            mis           <= '0;
            idx           <= '0;
            sj.nCorrect   <= '0;
            sj.nMisplaced <= '0;
            sj.tries      <= '0;
            sj.win        <= 1'b0;
            sj.lose       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        g_q    <= sj.guess;
                        s_q    <= sj.secret;
                        g_used <= '0;
                        s_used <= '0;
                        cor    <= '0;
                        mis    <= '0;
                        idx    <= '0;
                    end
                end
                EXACT: begin
                    if (exact_hit) begin
                        cor        <= cor + 3'd1;
                        g_used[si] <= 1'b1;
                        s_used[si] <= 1'b1;
                    end
                    idx <= (idx == 4'd3) ? 4'd0 : idx + 4'd1;
                end
                MISP: begin
                    if (mis_hit) begin
                        mis        <= mis + 3'd1;
                        g_used[gi] <= 1'b1;
                        s_used[si] <= 1'b1;
                    end
                    idx <= idx + 4'd1;
                end
                UPDATE: begin
                    sj.nCorrect   <= {1'b0, cor};
                    sj.nMisplaced <= {1'b0, mis};
                    sj.tries      <= {tens_nxt, units_nxt};
                    // A correct final guess counts as a win, never a loss.
                    if (cor == 3'd4)  sj.win  <= 1'b1;
                    else if (is_max)  sj.lose <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_safe_judge.sv
// Randomized self-checking bench for safe_judge against a counting-based scoring model.
module tb_safe_judge;
    localparam int MAX_TRIES = 10;

    logic       clk;
    logic       reset;
    logic [2:0] state_dbg;

    safe_judge_if sj ();

    safe_judge #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk       (clk),
        .reset     (reset),
        .sj        (sj),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_errors;
    logic [17:0] exp_q[$];    // {nCorrect, nMisplaced, tries, win, lose}
    logic [17:0] m_last;
    int          m_tries;
    bit          m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mastermind score from digit histograms: misplaced = sum of per-digit minimum counts minus exact.
    function automatic logic [7:0] score_model(input logic [3:0][3:0] g, input logic [3:0][3:0] s);
        int cg[16];
        int cs[16];
        int ex, common;
        ex = 0; common = 0;
        for (int d = 0; d < 16; d++) begin cg[d] = 0; cs[d] = 0; end
        for (int p = 0; p < 4; p++) begin
            if (g[p] == s[p]) ex++;
            cg[g[p]]++;
            cs[s[p]]++;
        end
        for (int d = 0; d < 16; d++) common += (cg[d] < cs[d]) ? cg[d] : cs[d];
        return {4'(ex), 4'(common - ex)};
    endfunction

    function automatic logic [7:0] to_bcd(input int t);
        return {4'(t / 10), 4'(t % 10)};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_ncorrect"},   32'(sj.nCorrect),   32'(m_last[17:14]));
        check({tag, "_nmisplaced"}, 32'(sj.nMisplaced), 32'(m_last[13:10]));
        check({tag, "_tries"},      32'(sj.tries),      32'(m_last[9:2]));
        check({tag, "_win"},        32'(sj.win),        32'(m_last[1]));
        check({tag, "_lose"},       32'(sj.lose),       32'(m_last[0]));
        check({tag, "_busy"},       32'(sj.busy),       32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        sj.submit = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset   = 1'b0;
        m_tries = 0;
        m_done  = 1'b0;
        m_last  = '0;
        exp_q.delete();
    endtask

    function automatic bit guess_valid(input logic [3:0][3:0] g);
`ifdef SAFE_JUDGE_VALIDATE_EN
        for (int i = 0; i < 4; i++) if (g[i] > 4'd9) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic play(input string tag, input logic [3:0][3:0] g, input logic [3:0][3:0] s);
        logic [7:0]  sc;
        logic [17:0] e;
        bit          w, l;
        @(negedge clk);
        sj.submit = 1'b1;
        sj.guess  = g;
        sj.secret = s;
        @(posedge clk);
        #1;
        if (m_done || !guess_valid(g)) begin
            check({tag, "_busy_ignored"}, 32'(sj.busy), 32'd0);
            check({tag, "_reject"}, 32'(sj.reject), 32'(!m_done && !guess_valid(g)));
            @(negedge clk);
            sj.submit = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_reject_end"}, 32'(sj.reject), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check_outputs({tag, "_hold"});
        end else begin
            sc = score_model(g, s);
            m_tries++;
            w = (sc[7:4] == 4'd4);
            l = !w && (m_tries == MAX_TRIES);
            m_done = w || l;
            exp_q.push_back({sc, to_bcd(m_tries), w, l});
            check({tag, "_busy_start"}, 32'(sj.busy), 32'd1);
            @(negedge clk);
            sj.submit = 1'b0;
            sj.guess  = 16'($urandom);
            sj.secret = 16'($urandom);
            repeat (20) @(posedge clk);
            #1;
            check({tag, "_busy_k20"}, 32'(sj.busy), 32'd1);
            @(posedge clk);
            #1;
            e      = exp_q.pop_front();
            m_last = e;
            check_outputs(tag);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0][3:0] g, s;
        logic [3:0][3:0] wrong, right;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        sj.submit = 1'b0;
        sj.guess  = '0;
        sj.secret = '0;
        m_tries   = 0;
        m_done    = 1'b0;
        m_last    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_reject", 32'(sj.reject), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        right = {4'h1, 4'h2, 4'h3, 4'h4};
        wrong = {4'h5, 4'h5, 4'h5, 4'h5};

        play("win", right, right);
        check("win_flag", 32'(sj.win), 32'd1);
        play("after_win", {4'h4, 4'h3, 4'h2, 4'h1}, right);

        do_reset();
        play("reverse", {4'h4, 4'h3, 4'h2, 4'h1}, right);
        play("dups", {4'h1, 4'h2, 4'h1, 4'h1}, {4'h1, 4'h1, 4'h2, 4'h2});
        play("nibble_a", {4'h1, 4'h2, 4'hA, 4'h4}, right);

        // Submit coinciding with reset must be dropped.
        @(negedge clk);
        reset     = 1'b1;
        sj.submit = 1'b1;
        sj.guess  = right;
        sj.secret = right;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        sj.submit = 1'b0;
        m_tries = 0; m_done = 1'b0; m_last = '0;
        @(posedge clk);
        #1;
        check_outputs("rst_submit");

        // Ten wrong guesses lose; an eleventh correct guess is ignored.
        for (int i = 0; i < MAX_TRIES; i++) play("lose_seq", wrong, right);
        check("lose_flag", 32'(sj.lose), 32'd1);
        check("lose_tries", 32'(sj.tries), 32'h10);
        play("after_lose", right, right);

        // Abort an evaluation with reset after ten cycles.
        do_reset();
        @(negedge clk);
        sj.submit = 1'b1;
        sj.guess  = right;
        sj.secret = right;
        @(posedge clk);
        @(negedge clk);
        sj.submit = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        play("after_abort", {4'h1, 4'h2, 4'h4, 4'h3}, right);

        // Random play with a narrow digit range so hits are frequent.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (m_done && ($urandom_range(0, 1) == 0)) do_reset();
            for (int p = 0; p < 4; p++) begin
                g[p] = 4'($urandom_range(0, 3));
                s[p] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) g = s;
            play("rand", g, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/safe_judge.md
# safe_judge

Guess-evaluation stage of the safe-cracking game; directly upstream of the marquee display. It latches a four-digit guess against the four-digit secret on a submit pulse and scores it serially, Mastermind-style (exact hits, then misplaced hits with duplicate handling). It publishes nCorrect, nMisplaced, a two-digit BCD try count and the win/lose flags, which the marquee consumes unchanged.

## Interface

- MAX_TRIES, 10, tries allowed before lose; legal range 1..99.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- submit  in  1  one-cycle guess-submit pulse, already debounced
- guess  in  [3:0][3:0]  guess digits; [3] is leftmost
- secret  in  [3:0][3:0]  secret digits; same ordering
- nCorrect  out  4  exact hits of the last scored guess, 0..4
- nMisplaced  out  4  misplaced hits of the last scored guess, 0..4
- tries  out  [1:0][3:0]  BCD count of scored guesses; [1] tens, [0] units
- win  out  1  level; last guess had nCorrect==4
- lose  out  1  level; try limit reached without a win
- busy  out  1  evaluation in progress
- reject  out  1  one-cycle pulse, guess refused (see Configuration)

## Operation

- States: IDLE, EXACT, MISP, UPDATE, DONE.
- IDLE: submit=1 latches guess/secret into internal registers, clears working counters cor/mis and used flags gUsed[3:0]/sUsed[3:0], then enters EXACT.
- EXACT: one position p per cycle, p=0..3. If g[p]==s[p]: cor+1, set gUsed[p] and sUsed[p]. After p=3, enter MISP.
- MISP: one pair per cycle, 16 cycles; outer index gi=0..3, inner index si=0..3. If !gUsed[gi] && !sUsed[si] && g[gi]==s[si]: mis+1, set gUsed[gi] and sUsed[si]. After (3,3), enter UPDATE.
- UPDATE: nCorrect<=cor, nMisplaced<=mis, tries<=tries+1 in BCD (units 9->0 with tens carry).
  - If cor==4: win<=1, go to DONE.
  - Else if the new tries equals MAX_TRIES: lose<=1, go to DONE.
  - Else go to IDLE.
- DONE: terminal state. All outputs hold and submit is ignored; only reset leaves DONE.
- busy = state is EXACT, MISP or UPDATE.
- submit is ignored outside IDLE. Changes to guess/secret after latching have no effect on the guess being scored.
- win takes priority over lose when the final permitted guess is correct.

## Timing

- Reset: state IDLE; nCorrect=0, nMisplaced=0, tries=00, win=0, lose=0, busy=0, reject=0; internal registers cleared.
- Reset mid-evaluation aborts the evaluation. The partial score is never published.
- Submit sampled at edge k:
  - busy goes high after edge k.
  - MISP is entered after edge k+4.
  - UPDATE is entered after edge k+20.
  - New nCorrect/nMisplaced/tries/win/lose are visible after edge k+21, with busy low at the same time.
  - Total latency is 21 cycles; a new submit is accepted at edge k+22 at the earliest.
- Between updates, the outputs hold their values. The marquee samples them as stable levels.
- A submit arriving in the same cycle as reset is dropped.

## Configuration

- SAFE_JUDGE_VALIDATE_EN defined: in IDLE, a submit whose guess contains any digit >9 is refused.
  - reject pulses high for one cycle after the sampling edge.
  - State stays IDLE; tries and scores are unchanged.
- SAFE_JUDGE_VALIDATE_EN undefined:
  - reject is tied to 0.
  - All nibble values are accepted and compared literally.

## Test plan

- Secret 1,2,3,4; guess 1,2,3,4 -> after 21 cycles nCorrect=4, nMisplaced=0, tries=01, win=1; a further submit is ignored and tries stays 01.
- Secret 1,2,3,4; guess 4,3,2,1 -> nCorrect=0, nMisplaced=4, win=0, return to IDLE.
- Duplicates: secret 1,1,2,2; guess 1,2,1,1 -> nCorrect=1, nMisplaced=2.
- MAX_TRIES=10, ten wrong guesses (5,5,5,5 vs 1,2,3,4) -> tries counts 01..09 then 10 (tens=1, units=0), lose=1 on the tenth; a correct eleventh guess is ignored.
- Reset asserted at cycle 10 of an evaluation -> all outputs 0 and state IDLE; the next submit is scored normally with tries=01.
- With SAFE_JUDGE_VALIDATE_EN, guess 1,2,A,4 -> reject is a one-cycle pulse, busy stays 0, tries unchanged. Without the macro, the same guess is scored: nCorrect=3 against secret 1,2,3,4.
